// File: rtl/wb_arb_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADR_W  = 32;
    localparam int SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        DRAIN  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stalled-ack watchdog: counts consecutive enabled cycles and flags the cycle
// in which the count reaches TIMEOUT_CYCLES.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [15:0] count_q;

    // Asserted during the TIMEOUT_CYCLES-th stalled cycle so the arbiter can
    // abort on the very edge the count is reached.
    assign expired = count_en && !clear && (count_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear || expired) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/wishbone_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between two masters.
// Optional stalled-ack watchdog with abort/drain enabled by WB_ARB_TIMEOUT_EN.
module wishbone_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc_i,
    input  logic              m1_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m1_stb_i,
    input  logic              m0_we_i,
    input  logic              m1_we_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [ADR_W-1:0]  m0_adr_i,
    input  logic [ADR_W-1:0]  m1_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m0_ack_o,
    output logic              m1_ack_o,
    output logic              m0_int_o,
    output logic              m1_int_o,
`ifdef WB_ARB_TIMEOUT_EN
    output logic              m0_err_o,
    output logic              m1_err_o,
`endif
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [ADR_W-1:0]  s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_int_i
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wishbone_master_arbiter: TIMEOUT_CYCLES out of range 2..65535");
    end

    arb_state_e state_q;
    logic       last_grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    logic err0_q, err1_q;
    logic expired;
    logic in_grant;

    assign in_grant = (state_q == GRANT0) || (state_q == GRANT1);

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_grant || s_ack_i),
        .count_en(in_grant && s_stb_o && !s_ack_i),
        .expired (expired)
    );

    assign m0_err_o = err0_q;
    assign m1_err_o = err1_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            err0_q <= 1'b0;
            err1_q <= 1'b0;
`endif
            case (state_q)
                // On contention the master that did not win last time goes first.
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
                        state_q      <= GRANT0;
                        last_grant_q <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state_q      <= GRANT1;
                        last_grant_q <= 1'b1;
                    end
                end
                GRANT0: begin
                    if (!m0_cyc_i) begin
                        state_q <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                    end else if (expired) begin
                        state_q <= DRAIN;
                        err0_q  <= 1'b1;
`endif
                    end
                end
                GRANT1: begin
                    if (!m1_cyc_i) begin
                        state_q <= IDLE;
`ifdef WB_ARB_TIMEOUT_EN
                    end else if (expired) begin
                        state_q <= DRAIN;
                        err1_q  <= 1'b1;
`endif
                    end
                end
`ifdef WB_ARB_TIMEOUT_EN
                // last_grant_q still names the aborted master here.
                DRAIN: begin
                    if (!(last_grant_q ? m1_cyc_i : m0_cyc_i)) begin
                        state_q <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state_q)
            GRANT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
            end
            GRANT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    // Interrupts pass straight through, held low only while reset is applied.
    assign m0_int_o = s_int_i & ~rst;
    assign m1_int_o = s_int_i & ~rst;

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Directed self-checking bench for wishbone_master_arbiter; the watchdog
// scenario is included when WB_ARB_TIMEOUT_EN is defined.
module tb_wishbone_master_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o, m0_int_o, m1_int_o;
`ifdef WB_ARB_TIMEOUT_EN
    logic        m0_err_o, m1_err_o;
`endif
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_int_i;

    int          n_asrt = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;
    int          ack_cnt;

    always #5 clk = ~clk;

    wishbone_master_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m1_cyc_i(m1_cyc_i),
        .m0_stb_i(m0_stb_i), .m1_stb_i(m1_stb_i),
        .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
        .m0_sel_i(m0_sel_i), .m1_sel_i(m1_sel_i),
        .m0_adr_i(m0_adr_i), .m1_adr_i(m1_adr_i),
        .m0_dat_i(m0_dat_i), .m1_dat_i(m1_dat_i),
        .m0_dat_o(m0_dat_o), .m1_dat_o(m1_dat_o),
        .m0_ack_o(m0_ack_o), .m1_ack_o(m1_ack_o),
        .m0_int_o(m0_int_o), .m1_int_o(m1_int_o),
`ifdef WB_ARB_TIMEOUT_EN
        .m0_err_o(m0_err_o), .m1_err_o(m1_err_o),
`endif
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_int_i(s_int_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        m0_cyc_i = 0; m1_cyc_i = 0; m0_stb_i = 0; m1_stb_i = 0;
        m0_we_i = 0; m1_we_i = 0; m0_sel_i = 0; m1_sel_i = 0;
        m0_adr_i = 0; m1_adr_i = 0; m0_dat_i = 0; m1_dat_i = 0;
        s_dat_i = 0; s_ack_i = 0; s_int_i = 0;

        // Reset state
        tick(); tick();
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_m0_ack", m0_ack_o, 0);
        chk("rst_s_adr", s_adr_o, 0);
        rst = 1'b0;

        // m0 alone write
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
        m0_adr_i = 32'h0000_0010; m0_dat_i = 32'hCAFE_F00D;
        sb_q.push_back(32'h0000_0010); sb_q.push_back(32'hCAFE_F00D);
        settle();
        chk("lat_s_cyc_idle", s_cyc_o, 0);
        tick();
        chk("wr_s_cyc", s_cyc_o, 1);
        exp_v = sb_q.pop_front(); chk("wr_s_adr", s_adr_o, exp_v);
        exp_v = sb_q.pop_front(); chk("wr_s_dat", s_dat_o, exp_v);
        chk("wr_s_we", s_we_o, 1);
        chk("wr_s_sel", s_sel_o, 32'hF);
        s_ack_i = 1; s_int_i = 1;
        settle();
        chk("wr_m0_ack", m0_ack_o, 1);
        chk("wr_m1_ack", m1_ack_o, 0);
        chk("int_m0", m0_int_o, 1);
        chk("int_m1", m1_int_o, 1);
        tick();
        s_ack_i = 0; s_int_i = 0; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
        settle();
        chk("wr_drop_s_cyc", s_cyc_o, 0);
        tick();

        // Contention from fresh reset: m0, then m1, then round-robin
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        m0_adr_i = 32'h0000_0100; m1_adr_i = 32'h0000_0200;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        sb_q.push_back(32'h100); sb_q.push_back(32'h200);
        sb_q.push_back(32'h100); sb_q.push_back(32'h200);
        tick();
        exp_v = sb_q.pop_front(); chk("rr1_adr", s_adr_o, exp_v);
        s_ack_i = 1; settle();
        chk("rr1_m1_ack", m1_ack_o, 0);
        chk("rr1_m1_dat", m1_dat_o, 0);
        tick();
        s_ack_i = 0;
        chk("rr1_hold_adr", s_adr_o, 32'h100);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("rr1_idle_cyc", s_cyc_o, 0);
        tick();
        chk("rr1_m1_cyc", s_cyc_o, 1);
        exp_v = sb_q.pop_front(); chk("rr1_m1_adr", s_adr_o, exp_v);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        exp_v = sb_q.pop_front(); chk("rr2_adr", s_adr_o, exp_v);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        exp_v = sb_q.pop_front(); chk("rr3_adr", s_adr_o, exp_v);
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();

        // m1 burst of 4 acks, m0 requests mid-burst
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
        tick();
        chk("bst_grant", s_adr_o, 32'h200);
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1; s_dat_i = 32'hD000_0000 + 32'(i);
            sb_q.push_back(32'hD000_0000 + 32'(i));
            if (i == 1) begin
                m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
            end
            settle();
            if (m1_ack_o === 1'b1) ack_cnt++;
            exp_v = sb_q.pop_front(); chk("bst_m1_dat", m1_dat_o, exp_v);
            chk("bst_m0_ack", m0_ack_o, 0);
            chk("bst_s_adr", s_adr_o, 32'h200);
            tick();
        end
        chk("bst_ack_cnt", 32'(ack_cnt), 4);
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        chk("bst_idle_cyc", s_cyc_o, 0);
        tick();
        chk("bst_m0_grant", s_adr_o, 32'h100);
        chk("bst_m0_cyc", s_cyc_o, 1);

        // Asynchronous reset mid-read with ack high
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        settle();
        chk("ar_pre_ack", m0_ack_o, 1);
        #1; rst = 1'b1; #1;
        chk("ar_s_cyc", s_cyc_o, 0);
        chk("ar_m0_ack", m0_ack_o, 0);
        chk("ar_m0_dat", m0_dat_o, 0);
        rst = 1'b0; #1;
        chk("ar_rel_s_cyc", s_cyc_o, 0);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("ar_idle_cyc", s_cyc_o, 0);
        m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        chk("ar_resume_cyc", s_cyc_o, 1);
        chk("ar_resume_adr", s_adr_o, 32'h200);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Stalled slave: abort after 8 cycles, drain, then grant m1
        rst = 1'b1; #2; rst = 1'b0;
        tick();
        m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        m1_cyc_i = 1; m1_stb_i = 1;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("to_stall_err", m0_err_o, 0);
            chk("to_stall_stb", s_stb_o, 1);
            tick();
        end
        chk("to_m0_err", m0_err_o, 1);
        chk("to_m1_err", m1_err_o, 0);
        tick();
        chk("to_err_pulse", m0_err_o, 0);
        chk("to_drain_stb", s_stb_o, 0);
        chk("to_drain_cyc", s_cyc_o, 0);
        tick();
        chk("to_drain2_cyc", s_cyc_o, 0);
        m0_cyc_i = 0; m0_stb_i = 0;
        tick();
        chk("to_idle_cyc", s_cyc_o, 0);
        tick();
        chk("to_m1_cyc", s_cyc_o, 1);
        chk("to_m1_adr", s_adr_o, 32'h200);
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbone_master_arbiter.md
WISHBONE_MASTER_ARBITER -- requirements
Module: wishbone_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the stalled-ack watchdog limit in clk cycles (range 2..65535).
REQ-002 SHALL have port clk  in  1  sole clock, all state on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports m0_cyc_i, m1_cyc_i  in  1  master cycle request.
REQ-005 SHALL have ports m0_stb_i, m1_stb_i, m0_we_i, m1_we_i  in  1  master strobe and write enable.
REQ-006 SHALL have ports m0_sel_i, m1_sel_i  in  4  master byte selects.
REQ-007 SHALL have ports m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i  in  32  master address and write data.
REQ-008 SHALL have ports m0_dat_o, m1_dat_o  out  32  read data to master.
REQ-009 SHALL have ports m0_ack_o, m1_ack_o, m0_int_o, m1_int_o  out  1  ack and interrupt to master.
REQ-010 SHALL have ports m0_err_o, m1_err_o  out  1  watchdog abort pulse; present only with WB_ARB_TIMEOUT_EN.
REQ-011 SHALL have ports s_cyc_o, s_stb_o, s_we_o  out  1, s_sel_o  out  4, s_adr_o, s_dat_o  out  32  shared bus to interconnect master port.
REQ-012 SHALL have ports s_dat_i  in  32, s_ack_i, s_int_i  in  1  shared bus return.

Function
REQ-013 SHALL implement states IDLE, GRANT0, GRANT1, plus DRAIN with WB_ARB_TIMEOUT_EN.
REQ-014 SHALL, in IDLE with only mN_cyc_i high, move to GRANTN on the next edge.
REQ-015 SHALL, in IDLE with both cyc high, grant the master not granted last (round-robin register last_grant, reset 1 so m0 wins first contention).
REQ-016 SHALL hold GRANTN while mN_cyc_i is high; other master's requests SHALL NOT preempt.
REQ-017 SHALL return GRANTN to IDLE on the edge where mN_cyc_i is sampled low, giving exactly one idle bus cycle between grants.
REQ-018 SHALL in GRANTN combinationally forward mN cyc/stb/we/sel/adr/dat to s_*, s_dat_i to mN_dat_o, s_ack_i to mN_ack_o (zero added latency inside a grant).
REQ-019 SHALL drive s_* outputs, and dat_o/ack_o of every non-granted master, to 0 when not granted.
REQ-020 SHALL drive m0_int_o and m1_int_o equal to s_int_i in all states.
REQ-021 SHALL let grant latency be one cycle: cyc raised in IDLE at edge k appears on s_cyc_o after edge k+1.

Reset
REQ-022 SHALL on rst force state IDLE, last_grant=1, watchdog count 0, all outputs 0 immediately, including mid-transfer.
REQ-023 SHALL resume arbitration on the first clk edge after rst deasserts.

Configuration
REQ-024 SHALL, with WB_ARB_TIMEOUT_EN defined, count consecutive GRANTN cycles with s_stb_o high and s_ack_i low, clearing on ack or leaving GRANTN.
REQ-025 SHALL, when the count reaches TIMEOUT_CYCLES, pulse mN_err_o for one cycle, enter DRAIN, and drive all s_* to 0 from the next cycle.
REQ-026 SHALL leave DRAIN for IDLE when the aborted master's cyc is sampled low; no grants issued in DRAIN.
REQ-027 SHALL, without WB_ARB_TIMEOUT_EN, omit counter, DRAIN and err ports; a stalled slave holds the grant indefinitely.

Structure
REQ-028 SHALL place the state enum (IDLE, GRANT0, GRANT1, DRAIN) and bus width constants (32 data/address, 4 select) in package wb_arb_pkg.
REQ-029 SHALL implement the watchdog counter as sub-module wb_arb_watchdog (inputs clk, rst, clear, count_en; output expired), instantiated only with WB_ARB_TIMEOUT_EN.

Verification
REQ-030 SHALL cover: m0 alone writes adr 0x0000_0010 dat 0xCAFE_F00D -> s_adr_o/s_dat_o match one cycle after cyc, m1_ack_o stays 0.
REQ-031 SHALL cover: m0, m1 raise cyc same edge from reset -> m0 granted first; after m0 drops cyc, one idle cycle, then m1 granted.
REQ-032 SHALL cover: second simultaneous contention after REQ-031 -> m0 granted (round-robin alternates).
REQ-033 SHALL cover: m1 granted, m0 requests mid-burst of 4 acks -> m0 waits until m1 cyc low; m1 sees all 4 acks.
REQ-034 SHALL cover: rst asserted mid-read with s_ack_i high -> s_cyc_o, m0_ack_o go 0 without a clock edge; idle after release.
REQ-035 SHALL cover (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks -> m0_err_o one-cycle pulse after 8 stalled cycles, s_stb_o 0 next cycle, m1 granted only after m0 drops cyc.
